// File: rtl/counter_event_fifo.sv
// Watches a 4-bit counter's RCO and LOAD edges and turns them into tagged event words.
// The words go into a small FIFO that a sink drains over a valid/ready handshake.
module counter_event_fifo #(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 4
) (
   input  logic                      clk,
   input  logic                      RESET,
   input  logic                      ENABLE,
   input  logic [3:0]                Q,
   input  logic                      RCO,
   input  logic                      LOAD,
   input  logic [1:0]                MODO,
   input  logic                      ev_ready,
   output logic                      ev_valid,
   output logic [8+SEQ_W-1:0]        ev_data,
   output logic [$clog2(DEPTH):0]    ev_count,
   output logic                      ovf,
   output logic [3:0]                drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int EV_W  = 8 + SEQ_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [EV_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [SEQ_W-1:0] r_seq;
   logic             r_rco_prev;
   logic             r_load_prev;
   logic             r_ovf;
   logic [3:0]       r_drop_cnt;

   logic             w_rco_ev;
   logic             w_load_ev;
   logic             w_event;
   logic             w_full;
   logic             w_valid;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [EV_W-1:0]  w_word;

   assign w_rco_ev  = RCO & ~r_rco_prev;
   assign w_load_ev = LOAD & ~r_load_prev;
   assign w_event   = (w_rco_ev | w_load_ev) & ENABLE;
   assign w_word    = {w_rco_ev, w_load_ev, MODO, Q, r_seq};

   assign w_full  = (r_count == FULL_CNT);
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & ev_ready;
   // A pop frees the head slot this same edge, so a full FIFO can still accept.
   assign w_push  = w_event & (~w_full | w_pop);
   assign w_drop  = w_event & w_full & ~w_pop;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_seq       <= '0;
         r_rco_prev  <= 1'b0;
         r_load_prev <= 1'b0;
         r_ovf       <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_rco_prev  <= RCO;
         r_load_prev <= LOAD;
         if (w_event) r_seq <= r_seq + SEQ_W'(1);
         if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 4'hF) r_drop_cnt <= r_drop_cnt + 4'd1;
         end
      end
   end

   // Storage holds data only; stale entries are unreachable once the count is cleared.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_word;
   end

   assign ev_valid   = w_valid;
   assign ev_data    = r_mem[r_rd_ptr];
   assign ev_count   = r_count;
   assign ovf        = r_ovf;
   assign drop_count = r_drop_cnt;

endmodule
